// File: rtl/riscv_multicycle_control.sv
// Control FSM for the multicycle RV32I datapath. Define RISCV_ILLEGAL_TRAP_EN to trap
// unrecognised opcodes in a sticky TRAP state; otherwise they execute as a NOP.
module riscv_multicycle_control #(
  parameter int STATE_W  = 4,
  parameter int ALUCTL_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                zero,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          result_src,
  output logic [2:0]          imm_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic [STATE_W-1:0]  state,
  output logic                illegal_instr
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    EXECUTEI = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    JAL      = STATE_W'(9),
    BRANCH   = STATE_W'(10)
`ifdef RISCV_ILLEGAL_TRAP_EN
    , TRAP   = STATE_W'(11)
`endif
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;

  localparam logic [ALUCTL_W-1:0] ALU_ADD  = ALUCTL_W'(4'b0000);
  localparam logic [ALUCTL_W-1:0] ALU_SUB  = ALUCTL_W'(4'b0001);
  localparam logic [ALUCTL_W-1:0] ALU_AND  = ALUCTL_W'(4'b0010);
  localparam logic [ALUCTL_W-1:0] ALU_OR   = ALUCTL_W'(4'b0011);
  localparam logic [ALUCTL_W-1:0] ALU_XOR  = ALUCTL_W'(4'b0100);
  localparam logic [ALUCTL_W-1:0] ALU_SLL  = ALUCTL_W'(4'b0101);
  localparam logic [ALUCTL_W-1:0] ALU_SRL  = ALUCTL_W'(4'b0110);
  localparam logic [ALUCTL_W-1:0] ALU_SRA  = ALUCTL_W'(4'b0111);
  localparam logic [ALUCTL_W-1:0] ALU_SLT  = ALUCTL_W'(4'b1000);
  localparam logic [ALUCTL_W-1:0] ALU_SLTU = ALUCTL_W'(4'b1001);

  state_e cur_state, nxt_state;

  // funct7b5 selects SUB only for register ops; ADDI has immediate bits there.
  function automatic logic [ALUCTL_W-1:0] alu_op(input logic [2:0] f3, input logic f7b5,
                                                 input logic is_reg);
    case (f3)
      3'b000:  alu_op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= FETCH;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    // NOTE: a default at the top of every combinational block keeps it latch-free.
    nxt_state = FETCH;
    case (cur_state)
      FETCH:  nxt_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: nxt_state = MEMADR;
          OP_RTYPE:          nxt_state = EXECUTER;
          OP_ITYPE:          nxt_state = EXECUTEI;
          OP_JAL:            nxt_state = JAL;
          OP_BRANCH:         nxt_state = BRANCH;
`ifdef RISCV_ILLEGAL_TRAP_EN
          default:           nxt_state = TRAP;
`else
          default:           nxt_state = FETCH;
`endif
        endcase
      end
      MEMADR:   nxt_state = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt_state = MEMWB;
      EXECUTER: nxt_state = ALUWB;
      EXECUTEI: nxt_state = ALUWB;
      JAL:      nxt_state = ALUWB;
`ifdef RISCV_ILLEGAL_TRAP_EN
      TRAP:     nxt_state = TRAP;
`endif
      default:  nxt_state = FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'd0;
    alu_src_b     = 2'd0;
    result_src    = 2'd0;
    imm_src       = IMM_I;
    alu_control   = ALU_ADD;
    illegal_instr = 1'b0;
    case (cur_state)
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
      end
      DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        imm_src   = IMM_B;
      end
      MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'd1;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        alu_src_a   = 2'd2;
        alu_control = alu_op(funct3, funct7b5, 1'b1);
      end
      EXECUTEI: begin
        alu_src_a   = 2'd2;
        alu_src_b   = 2'd1;
        alu_control = alu_op(funct3, funct7b5, 1'b0);
      end
      ALUWB:    reg_write = 1'b1;
      JAL: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        pc_write  = 1'b1;
      end
      BRANCH: begin
        alu_src_a   = 2'd2;
        alu_control = ALU_SUB;
        // Mealy term: the ALU compares rs1/rs2 this cycle, so zero is live.
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = ~zero;
          default: pc_write = 1'b0;
        endcase
      end
`ifdef RISCV_ILLEGAL_TRAP_EN
      TRAP:     illegal_instr = 1'b1;
`endif
      default: ;
    endcase
    // The async clear already shows FETCH; block its enables until reset releases.
    if (reset) begin
      pc_write  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Cycle-by-cycle vector table for riscv_multicycle_control plus hand-written sequences
// for the combinational branch term and mid-cycle asynchronous reset.
module tb_riscv_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_control, state;

  riscv_multicycle_control #(.STATE_W(4), .ALUCTL_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
    .alu_control(alu_control), .state(state), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  // Packed bundle: state, {pc_write,adr_src,mem_write,ir_write,reg_write}, src_a, src_b,
  // result_src, imm_src, alu_control, illegal_instr.
  typedef logic [22:0] bundle_t;

  localparam bundle_t E_RESET  = {4'd0,  5'b00000, 2'd0, 2'd2, 2'd2, 3'd0, 4'd0, 1'b0};
  localparam bundle_t E_FETCH  = {4'd0,  5'b10010, 2'd0, 2'd2, 2'd2, 3'd0, 4'd0, 1'b0};
  localparam bundle_t E_DECODE = {4'd1,  5'b00000, 2'd1, 2'd1, 2'd0, 3'd2, 4'd0, 1'b0};
  localparam bundle_t E_MA_LD  = {4'd2,  5'b00000, 2'd2, 2'd1, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam bundle_t E_MA_ST  = {4'd2,  5'b00000, 2'd2, 2'd1, 2'd0, 3'd1, 4'd0, 1'b0};
  localparam bundle_t E_MEMRD  = {4'd3,  5'b01000, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam bundle_t E_MEMWB  = {4'd4,  5'b00001, 2'd0, 2'd0, 2'd1, 3'd0, 4'd0, 1'b0};
  localparam bundle_t E_MEMWR  = {4'd5,  5'b01100, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam bundle_t E_ALUWB  = {4'd8,  5'b00001, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam bundle_t E_JAL    = {4'd9,  5'b10000, 2'd1, 2'd2, 2'd0, 3'd0, 4'd0, 1'b0};
  localparam bundle_t E_TRAP   = {4'd11, 5'b00000, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1'b1};

  function automatic bundle_t e_execr(input logic [3:0] alu);
    return {4'd6, 5'b00000, 2'd2, 2'd0, 2'd0, 3'd0, alu, 1'b0};
  endfunction
  function automatic bundle_t e_execi(input logic [3:0] alu);
    return {4'd7, 5'b00000, 2'd2, 2'd1, 2'd0, 3'd0, alu, 1'b0};
  endfunction
  function automatic bundle_t e_branch(input logic pcw);
    return {4'd10, pcw, 4'b0000, 2'd2, 2'd0, 2'd0, 3'd0, 4'd1, 1'b0};
  endfunction

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011, BAD = 7'b1111111;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    bundle_t    exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input bundle_t exp);
    vec_t v;
    v.rst = rst; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = exp;
    vecs.push_back(v);
  endtask

  function automatic bundle_t actual();
    return {state, pc_write, adr_src, mem_write, ir_write, reg_write,
            alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal_instr};
  endfunction

  task automatic check(input string name, input bundle_t act, input bundle_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %06h expected %06h (state got %0d expected %0d)",
               name, act, exp, act[22:19], exp[22:19]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    // Each row is one clock cycle: inputs applied just after the edge, outputs checked at negedge.
    add(1, RT, 3'b000, 1, 0, E_RESET);
    // R-type SUB: 0,1,6,8
    add(0, RT, 3'b000, 1, 0, E_FETCH);
    add(0, RT, 3'b000, 1, 0, E_DECODE);
    add(0, RT, 3'b000, 1, 0, e_execr(4'b0001));
    add(0, RT, 3'b000, 1, 0, E_ALUWB);
    // R-type SRA, ADD, SLTU
    add(0, RT, 3'b101, 1, 0, E_FETCH);
    add(0, RT, 3'b101, 1, 0, E_DECODE);
    add(0, RT, 3'b101, 1, 0, e_execr(4'b0111));
    add(0, RT, 3'b101, 1, 0, E_ALUWB);
    add(0, RT, 3'b000, 0, 0, E_FETCH);
    add(0, RT, 3'b000, 0, 0, E_DECODE);
    add(0, RT, 3'b000, 0, 0, e_execr(4'b0000));
    add(0, RT, 3'b000, 0, 0, E_ALUWB);
    add(0, RT, 3'b011, 0, 0, E_FETCH);
    add(0, RT, 3'b011, 0, 0, E_DECODE);
    add(0, RT, 3'b011, 0, 0, e_execr(4'b1001));
    add(0, RT, 3'b011, 0, 0, E_ALUWB);
    // I-type: ADDI ignores funct7b5, SRAI uses it, ANDI
    add(0, IT, 3'b000, 1, 0, E_FETCH);
    add(0, IT, 3'b000, 1, 0, E_DECODE);
    add(0, IT, 3'b000, 1, 0, e_execi(4'b0000));
    add(0, IT, 3'b000, 1, 0, E_ALUWB);
    add(0, IT, 3'b101, 1, 0, E_FETCH);
    add(0, IT, 3'b101, 1, 0, E_DECODE);
    add(0, IT, 3'b101, 1, 0, e_execi(4'b0111));
    add(0, IT, 3'b101, 1, 0, E_ALUWB);
    add(0, IT, 3'b111, 0, 0, E_FETCH);
    add(0, IT, 3'b111, 0, 0, E_DECODE);
    add(0, IT, 3'b111, 0, 0, e_execi(4'b0010));
    add(0, IT, 3'b111, 0, 0, E_ALUWB);
    // Load: 0,1,2,3,4
    add(0, LD, 3'b010, 0, 0, E_FETCH);
    add(0, LD, 3'b010, 0, 0, E_DECODE);
    add(0, LD, 3'b010, 0, 0, E_MA_LD);
    add(0, LD, 3'b010, 0, 0, E_MEMRD);
    add(0, LD, 3'b010, 0, 0, E_MEMWB);
    // Store: 0,1,2,5
    add(0, ST, 3'b010, 0, 0, E_FETCH);
    add(0, ST, 3'b010, 0, 0, E_DECODE);
    add(0, ST, 3'b010, 0, 0, E_MA_ST);
    add(0, ST, 3'b010, 0, 0, E_MEMWR);
    // Branches: BEQ taken/not, BNE inverted, BLT never writes PC
    add(0, BR, 3'b000, 0, 1, E_FETCH);
    add(0, BR, 3'b000, 0, 1, E_DECODE);
    add(0, BR, 3'b000, 0, 1, e_branch(1'b1));
    add(0, BR, 3'b000, 0, 0, E_FETCH);
    add(0, BR, 3'b000, 0, 0, E_DECODE);
    add(0, BR, 3'b000, 0, 0, e_branch(1'b0));
    add(0, BR, 3'b001, 0, 1, E_FETCH);
    add(0, BR, 3'b001, 0, 1, E_DECODE);
    add(0, BR, 3'b001, 0, 1, e_branch(1'b0));
    add(0, BR, 3'b001, 0, 0, E_FETCH);
    add(0, BR, 3'b001, 0, 0, E_DECODE);
    add(0, BR, 3'b001, 0, 0, e_branch(1'b1));
    add(0, BR, 3'b100, 0, 1, E_FETCH);
    add(0, BR, 3'b100, 0, 1, E_DECODE);
    add(0, BR, 3'b100, 0, 1, e_branch(1'b0));
    // JAL: 0,1,9,8
    add(0, JL, 3'b000, 0, 0, E_FETCH);
    add(0, JL, 3'b000, 0, 0, E_DECODE);
    add(0, JL, 3'b000, 0, 0, E_JAL);
    add(0, JL, 3'b000, 0, 0, E_ALUWB);
    // Load interrupted by reset during MEMWB: state must clear before the next edge
    add(0, LD, 3'b010, 0, 0, E_FETCH);
    add(0, LD, 3'b010, 0, 0, E_DECODE);
    add(0, LD, 3'b010, 0, 0, E_MA_LD);
    add(0, LD, 3'b010, 0, 0, E_MEMRD);
    add(1, LD, 3'b010, 0, 0, E_RESET);
    add(1, LD, 3'b010, 0, 0, E_RESET);
    add(0, LD, 3'b010, 0, 0, E_FETCH);
    add(0, LD, 3'b010, 0, 0, E_DECODE);
    add(0, LD, 3'b010, 0, 0, E_MA_LD);
    add(0, LD, 3'b010, 0, 0, E_MEMRD);
    add(0, LD, 3'b010, 0, 0, E_MEMWB);
    // Unrecognised opcode
    add(0, BAD, 3'b000, 0, 0, E_FETCH);
    add(0, BAD, 3'b000, 0, 0, E_DECODE);
`ifdef RISCV_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) add(0, BAD, 3'b000, 0, 0, E_TRAP);
    add(1, BAD, 3'b000, 0, 0, E_RESET);
    add(0, BAD, 3'b000, 0, 0, E_FETCH);
`else
    add(0, BAD, 3'b000, 0, 0, E_FETCH);
    add(0, BAD, 3'b000, 0, 0, E_DECODE);
    add(0, RT, 3'b000, 0, 0, E_FETCH);
`endif

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset = vecs[i].rst; opcode = vecs[i].op; funct3 = vecs[i].f3;
      funct7b5 = vecs[i].f7; zero = vecs[i].z;
      @(negedge clk);
      check($sformatf("vec%0d", i), actual(), vecs[i].exp);
    end

    // Branch pc_write follows zero and funct3 within the BRANCH cycle.
    @(posedge clk); #1;
    reset = 1'b1; opcode = BR; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("branch_state", actual(), e_branch(1'b0));
    zero = 1'b1;      #1; check_bit("beq_zero1", pc_write, 1'b1);
    funct3 = 3'b001;  #1; check_bit("bne_zero1", pc_write, 1'b0);
    zero = 1'b0;      #1; check_bit("bne_zero0", pc_write, 1'b1);
    funct3 = 3'b100;  #1; check_bit("blt_zero0", pc_write, 1'b0);

    // Reset asserted between edges in EXECUTER clears state without a clock.
    @(posedge clk); #1;
    reset = 1'b1; opcode = RT; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("execr_before_reset", actual(), e_execr(4'b0001));
    #2 reset = 1'b1;
    #1 check("async_reset_midcycle", actual(), E_RESET);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("fetch_after_reset", actual(), E_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
